// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// Byte/half stores are done as read-modify-write; one request is in flight at a time.
module lsu_mem_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDRWIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    input  logic [31:0]          req_addr_i,
    input  logic [WIDTH-1:0]     req_wdata_i,
    output logic                 resp_valid_o,
    output logic                 resp_err_o,
    output logic [WIDTH-1:0]     resp_rdata_o,
    output logic                 mem_write_d,
    output logic                 mem_read_d,
    output logic [ADDRWIDTH-1:0] addr_d,
    output logic [WIDTH-1:0]     write_data_d,
    input  logic [WIDTH-1:0]     read_data_q
);

    localparam int unsigned AHI = ADDRWIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [1:0]            r_size;
    logic [1:0]            r_lane;
    logic                  r_unsigned;
    logic [15:0]           r_wdata;

    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_ready;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [WIDTH-1:0]      r_resp_rdata;
    logic [ADDRWIDTH-1:0]  r_addr;
    logic [WIDTH-1:0]      r_write_data;

    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_ready;
    logic                  w_resp_valid;
    logic                  w_resp_err;
    logic [WIDTH-1:0]      w_resp_rdata;
    logic [ADDRWIDTH-1:0]  w_addr;
    logic [WIDTH-1:0]      w_write_data;
    logic                  w_req_err;
    logic                  w_accept;

    // Pick the addressed lane out of a memory word and extend it to WIDTH.
    function automatic logic [WIDTH-1:0] f_extend(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       size,
        input logic [1:0]       lane,
        input logic             uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lane, 3'b000} +: 8];
        h = d[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   f_extend = uns ? {{(WIDTH-8){1'b0}}, b}  : {{(WIDTH-8){b[7]}}, b};
            2'b01:   f_extend = uns ? {{(WIDTH-16){1'b0}}, h} : {{(WIDTH-16){h[15]}}, h};
            default: f_extend = d;
        endcase
    endfunction

    // Replace the addressed byte or halfword lane, leaving the rest of the word intact.
    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0] d,
        input logic [15:0]      wd,
        input logic [1:0]       size,
        input logic [1:0]       lane
    );
        f_merge = d;
        if (size == 2'b00) begin
            f_merge[{lane, 3'b000} +: 8] = wd[7:0];
        end else begin
            f_merge[{lane[1], 4'b0000} +: 16] = wd;
        end
    endfunction

    assign w_req_err = (req_size_i == 2'b11)
                     | ((req_size_i == 2'b01) & req_addr_i[0])
                     | ((req_size_i == 2'b10) & (|req_addr_i[1:0]))
                     | (|req_addr_i[31:AHI]);

    assign w_accept = (r_state == S_IDLE) && req_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the next value of every registered output.
    always_comb begin
        w_next       = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_err   = 1'b0;
        w_resp_rdata = '0;
        w_addr       = r_addr;
        w_write_data = r_write_data;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (req_valid_i) begin
                    w_ready = 1'b0;
                    w_addr  = req_addr_i[AHI-1:2];
                    if (w_req_err) begin
                        w_next       = S_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                    end else if (!req_we_i) begin
                        w_next     = S_RD;
                        w_mem_read = 1'b1;
                    end else if (req_size_i == 2'b10) begin
                        w_next       = S_WR;
                        w_mem_write  = 1'b1;
                        w_write_data = req_wdata_i;
                    end else begin
                        w_next     = S_RMW_RD;
                        w_mem_read = 1'b1;
                    end
                end
            end
            S_RD: begin
                w_next       = S_RESP;
                w_resp_valid = 1'b1;
                w_resp_rdata = f_extend(read_data_q, r_size, r_lane, r_unsigned);
            end
            S_RMW_RD: begin
                w_next       = S_WR;
                w_mem_write  = 1'b1;
                w_write_data = f_merge(read_data_q, r_wdata, r_size, r_lane);
            end
            S_WR: begin
                w_next       = S_RESP;
                w_resp_valid = 1'b1;
            end
            S_RESP: begin
                w_next  = S_IDLE;
                w_ready = 1'b1;
            end
            default: begin
                w_next  = S_IDLE;
                w_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_size     <= req_size_i;
            r_lane     <= req_addr_i[1:0];
            r_unsigned <= req_unsigned_i;
            r_wdata    <= req_wdata_i[15:0];
        end
    end

    // Enables are one-hot with RD/RMW_RD/WR, so reset drops them immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_addr       <= '0;
            r_write_data <= '0;
        end else begin
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_ready      <= w_ready;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_resp_err;
            r_resp_rdata <= w_resp_rdata;
            r_addr       <= w_addr;
            r_write_data <= w_write_data;
        end
    end

    assign req_ready_o  = r_ready;
    assign resp_valid_o = r_resp_valid;
    assign resp_err_o   = r_resp_err;
    assign resp_rdata_o = r_resp_rdata;
    assign mem_read_d   = r_mem_read;
    assign mem_write_d  = r_mem_write;
    assign addr_d       = r_addr;
    assign write_data_d = r_write_data;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a driver queues expected responses, a monitor
// pops and checks them, with a behavioural word memory attached.
module tb_lsu_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        mem_write_d;
    logic        mem_read_d;
    logic [9:0]  addr_d;
    logic [31:0] write_data_d;
    logic [31:0] read_data_q;

    always #5 clk_i = ~clk_i;

    lsu_mem_ctrl #(.WIDTH(32), .ADDRWIDTH(10)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_err_o     (resp_err_o),
        .resp_rdata_o   (resp_rdata_o),
        .mem_write_d    (mem_write_d),
        .mem_read_d     (mem_read_d),
        .addr_d         (addr_d),
        .write_data_d   (write_data_d),
        .read_data_q    (read_data_q)
    );

    // Word memory; a garbage pattern stands in for the floating bus when not read.
    logic [31:0] mem [0:1023];
    always @(posedge clk_i) if (mem_write_d) mem[addr_d] <= write_data_d;
    assign read_data_q = mem_read_d ? mem[addr_d] : 32'hDEAD_0BAD;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned rd_cnt = 0;
    int unsigned wr_cnt = 0;
    logic [9:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic report_and_finish();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Monitor: enable bookkeeping and scoreboard compare on each response pulse.
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (mem_read_d && mem_write_d) begin
                n_checks++;
                $display("FAIL rd_wr_exclusive: both enables high at cycle %0d", cyc);
            end
            if (mem_read_d) rd_cnt++;
            if (mem_write_d) begin
                wr_cnt++;
                last_wr_addr = addr_d;
                last_wr_data = write_data_d;
            end
            if (!resp_valid_o && resp_rdata_o != 32'h0) begin
                n_checks++;
                $display("FAIL rdata_idle: got 0x%08h outside a response, expected 0", resp_rdata_o);
            end
            if (resp_valid_o) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: pulse at cycle %0d, err=%b rdata=0x%08h, expected none",
                             cyc, resp_err_o, resp_rdata_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    check({mon_e.name, "_err"}, 32'(resp_err_o), 32'(mon_e.err));
                    check({mon_e.name, "_rdata"}, resp_rdata_o, mon_e.rdata);
                    check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    // Drive a request at a negedge and wait for acceptance; lat=0 pushes no expectation.
    task automatic issue(input string nm, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input int unsigned lat, input logic hold,
                         output int unsigned acc);
        int unsigned n;
        exp_t        e;
        n = 0;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            n_checks++;
            $display("FAIL %s_accept: ready=0 after %0d cycles, expected 1", nm, n);
            report_and_finish();
        end
        acc = cyc + 1;
        if (lat != 0) begin
            e.name  = nm;
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.cyc   = acc + lat - 1;
            sb_q.push_back(e);
        end
        @(negedge clk_i);
        if (!hold) req_valid_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int unsigned n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({nm, "_drain"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        report_and_finish();
    end

    initial begin
        int unsigned a1, a2, r0, w0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk_i);
        check("rst_enables", {30'd0, mem_read_d, mem_write_d}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_ready",      32'(req_ready_o),  32'd1);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_resp_err",   32'(resp_err_o),   32'd0);
        check("rst_resp_rdata", resp_rdata_o,      32'd0);
        check("rst_addr",       32'(addr_d),       32'd0);
        check("rst_wdata",      write_data_d,      32'd0);

        // Word store then load
        w0 = wr_cnt;
        issue("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b0, a1);
        drain("sw_10");
        check("sw_10_wr_cycles", 32'(wr_cnt - w0), 32'd1);
        check("sw_10_addr",      32'(last_wr_addr), 32'd4);
        check("sw_10_data",      last_wr_data,      32'hDEAD_BEEF);
        issue("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0, a1);

        // Byte store through read-modify-write
        drain("lw_10");
        r0 = rd_cnt; w0 = wr_cnt;
        issue("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, 1'b0, 32'h0, 3, 1'b0, a1);
        drain("sb_11");
        check("sb_11_rd_cycles", 32'(rd_cnt - r0), 32'd1);
        check("sb_11_wr_cycles", 32'(wr_cnt - w0), 32'd1);
        check("sb_11_data",      last_wr_data,     32'hDEAD_5AEF);
        issue("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_5AEF, 2, 1'b0, a1);

        // Sub-word loads with sign and zero extension
        issue("sw_lanes", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80AA_5A11, 1'b0, 32'h0, 2, 1'b0, a1);
        issue("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 1'b0, a1);
        issue("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 2, 1'b0, a1);
        issue("lh_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_80AA, 2, 1'b0, a1);
        issue("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_5A11, 2, 1'b0, a1);
        issue("lb_11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_005A, 2, 1'b0, a1);

        // Halfword store into the upper lane
        issue("sh_12",  1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, 1'b0, 32'h0, 3, 1'b0, a1);
        issue("lw_sh",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5A11, 2, 1'b0, a1);
        drain("sh_12");

        // Error requests: one-cycle latency, no memory enables
        r0 = rd_cnt; w0 = wr_cnt;
        issue("err_lw_2",   1'b0, 2'b10, 1'b0, 32'h2,    32'h0, 1'b1, 32'h0, 1, 1'b0, a1);
        issue("err_sh_1",   1'b1, 2'b01, 1'b0, 32'h1,    32'h0, 1'b1, 32'h0, 1, 1'b0, a1);
        issue("err_size",   1'b0, 2'b11, 1'b0, 32'h0,    32'h0, 1'b1, 32'h0, 1, 1'b0, a1);
        issue("err_range",  1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1, 1'b0, a1);
        issue("err_sw_rng", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h1, 1'b1, 32'h0, 1, 1'b0, a1);
        drain("errors");
        check("err_rd_cycles", 32'(rd_cnt - r0), 32'd0);
        check("err_wr_cycles", 32'(wr_cnt - w0), 32'd0);

        // Back-to-back with valid held high: next accept on first IDLE cycle
        issue("b2b_lw",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5A11, 2, 1'b1, a1);
        issue("b2b_lbu", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_0012, 2, 1'b0, a2);
        check("b2b_load_gap", 32'(a2 - a1), 32'd3);
        drain("b2b_load");
        issue("b2b_sw",  1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1'b1, a1);
        issue("b2b_lw2", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 1'b0, a2);
        check("b2b_store_gap", 32'(a2 - a1), 32'd3);
        drain("b2b_store");

        // Reset pulsed during RMW_RD of a byte store
        w0 = wr_cnt;
        issue("sb_rst", 1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_00FF, 1'b0, 32'h0, 0, 1'b0, a1);
        check("rmw_rd_active", 32'(mem_read_d), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_async_enables", {30'd0, mem_read_d, mem_write_d}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("rst2_ready", 32'(req_ready_o), 32'd1);
        check("rst2_addr",  32'(addr_d),      32'd0);
        check("rst2_wdata", write_data_d,     32'd0);
        check("rst2_wr_cycles", 32'(wr_cnt - w0), 32'd0);
        check("rst2_mem_word",  mem[4],           32'h1234_5A11);
        issue("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5A11, 2, 1'b0, a1);
        drain("after_rst");
        repeat (3) @(negedge clk_i);
        report_and_finish();
    end

endmodule
